// File: rtl/control_sequencer.sv
// Multi-cycle accumulator machine sequencer: fetches, decodes and executes
// single-address instructions against an external memory and combinational ALU.
module control_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic [11:0] pc,
  output logic [15:0] acc,
  output logic [15:0] ir,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_OPRD   = 3'd3,
    S_EXEC   = 3'd4,
    S_WRITE  = 3'd5
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JNZ   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  function automatic logic [3:0] alu_code(input logic [3:0] opc);
    case (opc)
      OP_ADD:  alu_code = 4'b0000;
      OP_SUB:  alu_code = 4'b0001;
      OP_SHL:  alu_code = 4'b0100;
      OP_SHR:  alu_code = 4'b0101;
      OP_AND:  alu_code = 4'b1000;
      OP_OR:   alu_code = 4'b1001;
      OP_XOR:  alu_code = 4'b1010;
      default: alu_code = 4'b0000;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [11:0] pc_r, pc_s;
  logic [15:0] acc_r, acc_s;
  logic [15:0] ir_r, ir_s;
  logic        halted_r, halted_s;
  logic        busy_r;
  logic [15:0] mem_addr_r, mem_addr_s;
  logic        mem_we_r, mem_we_s;
  logic [3:0]  alu_op_r;

  // Next-state and datapath update; jump decisions use the word arriving in DECODE.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    acc_s    = acc_r;
    ir_s     = ir_r;
    halted_s = halted_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s  = S_FETCH;
          halted_s = 1'b0;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_FETCH: state_s = S_DECODE;
      S_DECODE: begin
        ir_s = mem_rdata;
        pc_s = pc_r + 12'd1;
        case (mem_rdata[15:12])
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_s = S_OPRD;
          OP_SHL, OP_SHR: state_s = S_EXEC;
          OP_STORE:       state_s = S_WRITE;
          OP_JUMP: begin
            pc_s    = mem_rdata[11:0];
            state_s = S_FETCH;
          end
          OP_JZ: begin
            if (acc_r == 16'h0000) begin
              pc_s = mem_rdata[11:0];
            end else begin
              pc_s = pc_r + 12'd1;
            end
            state_s = S_FETCH;
          end
          OP_JNZ: begin
            if (acc_r != 16'h0000) begin
              pc_s = mem_rdata[11:0];
            end else begin
              pc_s = pc_r + 12'd1;
            end
            state_s = S_FETCH;
          end
          OP_HALT: begin
            halted_s = 1'b1;
            state_s  = S_IDLE;
          end
          default: state_s = S_FETCH;
        endcase
      end
      S_OPRD: state_s = S_EXEC;
      S_EXEC: begin
        if (ir_r[15:12] == OP_LOAD) begin
          acc_s = mem_rdata;
        end else begin
          acc_s = alu_result;
        end
        state_s = S_FETCH;
      end
      S_WRITE: state_s = S_FETCH;
      default: state_s = S_IDLE;
    endcase
  end

  // Memory strobes are computed from the upcoming state so they can be registered.
  always_comb begin
    mem_addr_s = 16'h0000;
    mem_we_s   = 1'b0;
    case (state_s)
      S_FETCH: mem_addr_s = {4'h0, pc_s};
      S_OPRD:  mem_addr_s = {4'h0, ir_s[11:0]};
      S_WRITE: begin
        mem_addr_s = {4'h0, ir_s[11:0]};
        mem_we_s   = 1'b1;
      end
      default: mem_addr_s = 16'h0000;
    endcase
  end

  // State and output registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      pc_r       <= RESET_PC;
      acc_r      <= 16'h0000;
      ir_r       <= 16'h0000;
      halted_r   <= 1'b0;
      busy_r     <= 1'b0;
      mem_addr_r <= 16'h0000;
      mem_we_r   <= 1'b0;
      alu_op_r   <= 4'b0000;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      acc_r      <= acc_s;
      ir_r       <= ir_s;
      halted_r   <= halted_s;
      busy_r     <= (state_s != S_IDLE);
      mem_addr_r <= mem_addr_s;
      mem_we_r   <= mem_we_s;
      alu_op_r   <= alu_code(ir_s[15:12]);
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = acc_r;
  assign alu_op    = alu_op_r;
  assign alu_a     = acc_r;
  assign alu_b     = mem_rdata;
  assign pc        = pc_r;
  assign acc       = acc_r;
  assign ir        = ir_r;
  assign busy      = busy_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: memory and ALU environment, directed vector table,
// multi-cycle corner sequences and random programs checked against an ISA model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result, acc, ir;
  logic        mem_we, busy, halted;
  logic [3:0]  alu_op;
  logic [11:0] pc;

  control_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .pc(pc), .acc(acc), .ir(ir), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  logic [15:0] img [0:4095];
  logic [15:0] mm  [0:4095];
  logic        load_img = 1'b0;

  // Synchronous memory; img is copied in while load_img is high
  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < 4096; i++) mem[i] <= img[i];
    end else if (mem_we) begin
      mem[mem_addr[11:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[11:0]];
  end

  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0100: alu_result = alu_a << 1;
      4'b0101: alu_result = alu_a >> 1;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 4096; i++) img[i] = 16'hF000;
  endtask

  task automatic boot();
    reset = 1'b1;
    start = 1'b0;
    load_img = 1'b1;
    tick();
    load_img = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic run(output int cyc, output bit timeout);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      tick();
    end
    timeout = busy;
  endtask

  // Instruction-level reference: executes img from pc 0 with acc 0
  task automatic model_run(output logic [15:0] macc, output logic [11:0] mpc, output int mcyc);
    logic [15:0] ins;
    logic [11:0] a;
    bit done;
    for (int i = 0; i < 4096; i++) mm[i] = img[i];
    macc = 16'h0000;
    mpc = 12'h000;
    mcyc = 0;
    done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      ins = mm[mpc];
      a = ins[11:0];
      mpc = mpc + 12'd1;
      case (ins[15:12])
        4'h0: begin macc = mm[a]; mcyc += 4; end
        4'h1: begin mm[a] = macc; mcyc += 3; end
        4'h2: begin macc = macc + mm[a]; mcyc += 4; end
        4'h3: begin macc = macc - mm[a]; mcyc += 4; end
        4'h4: begin macc = macc & mm[a]; mcyc += 4; end
        4'h5: begin macc = macc | mm[a]; mcyc += 4; end
        4'h6: begin macc = macc ^ mm[a]; mcyc += 4; end
        4'h7: begin macc = {macc[14:0], 1'b0}; mcyc += 3; end
        4'h8: begin macc = {1'b0, macc[15:1]}; mcyc += 3; end
        4'h9: begin mpc = a; mcyc += 2; end
        4'hA: begin if (macc == 16'h0000) mpc = a; mcyc += 2; end
        4'hB: begin if (macc != 16'h0000) mpc = a; mcyc += 2; end
        4'hF: begin mcyc += 2; done = 1'b1; end
        default: mcyc += 2;
      endcase
    end
  endtask

  typedef struct {
    logic [15:0] a0;
    logic [15:0] instr;
    logic [15:0] opnd;
    logic [15:0] exp_acc;
    logic [15:0] exp_mem;
    logic [11:0] exp_pc;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [0:14];

  initial begin
    int cyc, w, mcyc;
    bit to;
    logic [15:0] macc, op16;
    logic [11:0] mpc, a;
    logic [3:0] op;

    reset = 1'b1;
    start = 1'b0;
    #2;
    check("rst_pc", {20'h0, pc}, 32'h0);
    check("rst_acc", {16'h0, acc}, 32'h0);
    check("rst_ir", {16'h0, ir}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_addr", {16'h0, mem_addr}, 32'h0);

    vecs = '{
      '{16'h1234, 16'h0101, 16'hBEEF, 16'hBEEF, 16'hBEEF, 12'h003, 10},
      '{16'hFFFF, 16'h2101, 16'h0002, 16'h0001, 16'h0002, 12'h003, 10},
      '{16'h0000, 16'h3101, 16'h0001, 16'hFFFF, 16'h0001, 12'h003, 10},
      '{16'hF0F0, 16'h4101, 16'h3C3C, 16'h3030, 16'h3C3C, 12'h003, 10},
      '{16'hF0F0, 16'h5101, 16'h0F01, 16'hFFF1, 16'h0F01, 12'h003, 10},
      '{16'hFF00, 16'h6101, 16'h0FF0, 16'hF0F0, 16'h0FF0, 12'h003, 10},
      '{16'h8001, 16'h7000, 16'h1111, 16'h0002, 16'h1111, 12'h003, 9},
      '{16'h8001, 16'h8000, 16'h1111, 16'h4000, 16'h1111, 12'h003, 9},
      '{16'h0000, 16'hA0A5, 16'h1111, 16'h0000, 16'h1111, 12'h0A6, 8},
      '{16'h0001, 16'hA0A5, 16'h1111, 16'h0001, 16'h1111, 12'h003, 8},
      '{16'h0005, 16'hB0A5, 16'h1111, 16'h0005, 16'h1111, 12'h0A6, 8},
      '{16'h0000, 16'hB0A5, 16'h1111, 16'h0000, 16'h1111, 12'h003, 8},
      '{16'h0007, 16'h90A5, 16'h1111, 16'h0007, 16'h1111, 12'h0A6, 8},
      '{16'h4321, 16'hD000, 16'h1111, 16'h4321, 16'h1111, 12'h003, 8},
      '{16'h5A5A, 16'h1101, 16'h1111, 16'h5A5A, 16'h5A5A, 12'h003, 9}
    };

    for (int v = 0; v < 15; v++) begin
      fill_halt();
      img[0] = 16'h0100;
      img[12'h100] = vecs[v].a0;
      img[1] = vecs[v].instr;
      img[12'h101] = vecs[v].opnd;
      boot();
      run(cyc, to);
      check($sformatf("vec%0d_timeout", v), {31'h0, to}, 32'h0);
      check($sformatf("vec%0d_acc", v), {16'h0, acc}, {16'h0, vecs[v].exp_acc});
      check($sformatf("vec%0d_pc", v), {20'h0, pc}, {20'h0, vecs[v].exp_pc});
      check($sformatf("vec%0d_mem", v), {16'h0, mem[12'h101]}, {16'h0, vecs[v].exp_mem});
      check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cyc);
      check($sformatf("vec%0d_halted", v), {31'h0, halted}, 32'h1);
      check($sformatf("vec%0d_ir", v), {16'h0, ir}, 32'h0000F000);
    end

    // Reference program with start held high during the first busy cycles
    fill_halt();
    img[0] = 16'h0010; img[1] = 16'h2011; img[2] = 16'h1012; img[3] = 16'hF000;
    img[12'h010] = 16'h0005; img[12'h011] = 16'h0007;
    boot();
    start = 1'b1;
    tick();
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == 6) start = 1'b0;
      tick();
    end
    start = 1'b0;
    check("prog_cycles", cyc, 13);
    check("prog_acc", {16'h0, acc}, 32'h000C);
    check("prog_mem12", {16'h0, mem[12'h012]}, 32'h000C);
    check("prog_pc", {20'h0, pc}, 32'h004);
    check("prog_halted", {31'h0, halted}, 32'h1);
    // Restart after HALT resumes at the current pc
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_halted", {31'h0, halted}, 32'h0);
    check("restart_busy", {31'h0, busy}, 32'h1);
    check("restart_addr", {16'h0, mem_addr}, 32'h0004);
    w = 0;
    while (busy && w < 50) begin w++; tick(); end
    check("restart_done", {31'h0, busy}, 32'h0);
    check("restart_pc", {20'h0, pc}, 32'h005);
    check("restart_acc", {16'h0, acc}, 32'h000C);

    // pc wrap from 0xFFF to 0x000
    fill_halt();
    img[0] = 16'h9FFF;
    img[12'hFFF] = 16'hC000;
    boot();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wrap_fetch0", {16'h0, mem_addr}, 32'h0000);
    tick();
    check("wrap_decode_addr", {16'h0, mem_addr}, 32'h0000);
    tick();
    check("wrap_fetch_fff", {16'h0, mem_addr}, 32'h0FFF);
    tick();
    tick();
    check("wrap_fetch_000", {16'h0, mem_addr}, 32'h0000);
    check("wrap_pc", {20'h0, pc}, 32'h000);
    check("wrap_busy", {31'h0, busy}, 32'h1);

    // Asynchronous reset in the WRITE cycle
    fill_halt();
    img[0] = 16'h0051; img[12'h051] = 16'hABCD; img[1] = 16'h1050;
    boot();
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!mem_we && w < 20) begin tick(); w++; end
    check("wr_seen_we", {31'h0, mem_we}, 32'h1);
    check("wr_acc_before", {16'h0, acc}, 32'hABCD);
    #1 reset = 1'b1;
    #1;
    check("wr_rst_we", {31'h0, mem_we}, 32'h0);
    check("wr_rst_addr", {16'h0, mem_addr}, 32'h0);
    check("wr_rst_busy", {31'h0, busy}, 32'h0);
    check("wr_rst_pc", {20'h0, pc}, 32'h0);
    check("wr_rst_acc", {16'h0, acc}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("post_rst_idle", {31'h0, busy}, 32'h0);
    check("post_rst_addr", {16'h0, mem_addr}, 32'h0);

    // Random forward-branching programs against the reference model
    for (int t = 0; t < 30; t++) begin
      fill_halt();
      for (int i = 0; i < 32; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h2;
        if (op == 4'h9 || op == 4'hA || op == 4'hB) a = 12'($urandom_range(i + 1, 32));
        else if (op <= 4'h8) a = 12'h040 + 12'($urandom_range(0, 15));
        else a = 12'($urandom);
        img[i] = {op, a};
      end
      for (int j = 0; j < 16; j++) begin
        op16 = 16'($urandom);
        img[12'h040 + j] = op16;
      end
      model_run(macc, mpc, mcyc);
      boot();
      run(cyc, to);
      check($sformatf("rnd%0d_timeout", t), {31'h0, to}, 32'h0);
      check($sformatf("rnd%0d_acc", t), {16'h0, acc}, {16'h0, macc});
      check($sformatf("rnd%0d_pc", t), {20'h0, pc}, {20'h0, mpc});
      check($sformatf("rnd%0d_cycles", t), cyc, mcyc);
      check($sformatf("rnd%0d_halted", t), {31'h0, halted}, 32'h1);
      for (int j = 0; j < 16; j++)
        check($sformatf("rnd%0d_mem%0d", t, j), {16'h0, mem[12'h040 + j]}, {16'h0, mm[12'h040 + j]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The module SHALL have one parameter: RESET_PC, default 12'h000, the PC value loaded on reset.
REQ-002 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous active-high reset
- start  in  1  leaves IDLE and begins fetching
- mem_addr  out  16  main-memory address, {4'b0, 12-bit field}
- mem_wdata  out  16  memory write data, always equal to acc
- mem_we  out  1  memory write enable
- mem_rdata  in  16  memory read data; valid one cycle after the address is presented with mem_we=0
- alu_op  out  4  ALU operation code
- alu_a  out  16  ALU operand 1, always equal to acc
- alu_b  out  16  ALU operand 2, always equal to mem_rdata
- alu_result  in  16  combinational ALU result
- pc  out  12  program counter
- acc  out  16  accumulator
- ir  out  16  instruction register
- busy  out  1  high in every state except IDLE
- halted  out  1  set by HALT; cleared by start or reset

Function
REQ-004 The instruction format SHALL be ir[15:12] = opcode and ir[11:0] = addr.
REQ-005 Opcodes SHALL be decoded as follows; 0xC-0xE SHALL behave as NOP:
- 0 LOAD: acc<=M[addr]
- 1 STORE: M[addr]<=acc
- 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: acc<=acc op M[addr]
- 7 SHL, 8 SHR: operate on acc only
- 9 JUMP
- A JZ: jump if acc==0
- B JNZ: jump if acc!=0
- F HALT
REQ-006 alu_op SHALL map as follows, and SHALL be 4'b0000 for all other opcodes: ADD->0000, SUB->0001, SHL->0100, SHR->0101, AND->1000, OR->1001, XOR->1010.
REQ-007 The FSM SHALL have the states IDLE, FETCH, DECODE, OPRD, EXEC and WRITE.
REQ-008 In IDLE, start=1 SHALL go to FETCH and clear halted; start SHALL be ignored in every other state.
REQ-009 In FETCH, mem_addr SHALL be {4'b0,pc} with mem_we=0, and the next state SHALL be DECODE.
REQ-010 In DECODE, ir SHALL be loaded from mem_rdata and pc SHALL become pc+1, except that a taken jump loads pc<=mem_rdata[11:0].
REQ-011 From DECODE, the next state SHALL be selected by the decoded opcode:
- LOAD or ADD..XOR -> OPRD
- SHL/SHR -> EXEC
- STORE -> WRITE
- JUMP/JZ/JNZ/NOP -> FETCH
- HALT -> IDLE with halted<=1
REQ-012 JZ/JNZ in DECODE SHALL test the current acc value.
REQ-013 In OPRD, mem_addr SHALL be {4'b0,ir[11:0]} with mem_we=0, and the next state SHALL be EXEC.
REQ-014 In EXEC, acc SHALL load mem_rdata for LOAD and alu_result otherwise, and the next state SHALL be FETCH.
REQ-015 In WRITE, mem_addr SHALL be {4'b0,ir[11:0]} with mem_we=1 and mem_wdata=acc, and the next state SHALL be FETCH.
REQ-016 mem_we SHALL be 1 only in WRITE.
REQ-017 mem_addr SHALL be 16'h0000 in IDLE, DECODE and EXEC.
REQ-018 Instruction latency in clocks from FETCH entry SHALL be:
- LOAD/ALU-with-operand: 4
- SHL/SHR: 3
- STORE: 3
- JUMP/JZ/JNZ/NOP/HALT: 2
REQ-019 pc+1 SHALL wrap from 12'hFFF to 12'h000 with no flag.
REQ-020 Arithmetic SHALL be modulo 2^16; carry and borrow SHALL be discarded, as the ALU does.
REQ-021 pc, acc and ir SHALL change only in the states listed above.
REQ-022 pc, acc and ir SHALL hold their values in IDLE.
REQ-023 An instruction at address 12'hFFF SHALL execute normally, after which fetch SHALL continue from 12'h000.

Reset
REQ-024 Asserting reset SHALL immediately, without waiting for clk, force:
- state=IDLE, pc=RESET_PC, acc=0, ir=0
- halted=0, busy=0
- mem_we=0, mem_addr=0
REQ-025 Reset asserted during WRITE SHALL drop mem_we in the same cycle; the write is not guaranteed.
REQ-026 After reset deasserts, the block SHALL stay in IDLE until start=1 is sampled.

Verification
REQ-027 Memory holds 0:0x0010, 1:0x2011, 2:0x1012, 3:0xF000, 0x10:0x0005, 0x11:0x0007; pulse start -> M[0x12]=0x000C, acc=0x000C, halted=1, pc=4, 13 busy cycles.
REQ-028 acc=0 at JZ 0x0A5 -> pc=0x0A5 after DECODE; acc=1 at the same JZ -> pc=next address, 2-cycle instruction.
REQ-029 acc=0x8001, SHL -> acc=0x0002; SUB with acc=0, M=1 -> acc=0xFFFF.
REQ-030 pc=12'hFFF holding a NOP -> next fetch mem_addr=16'h0000.
REQ-031 Reset asserted in the WRITE cycle -> mem_we=0 before the next edge, state=IDLE, pc=RESET_PC, acc=0.
REQ-032 start held high while busy -> no effect; start=1 in IDLE after HALT -> halted=0 and fetch resumes at the current pc.
